// File: rtl/bist_mac_engine.sv
// bist_mac_engine: pipelined y = x1*x2 + v*t + c with a
// self-test that runs after reset and again on request.
module bist_mac_engine #(
  parameter int WIDTH = 8,
  parameter int NUM_VECTORS = 4,
  localparam int RW = 2*WIDTH+2,
  localparam int IW = $clog2(NUM_VECTORS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bist_start,
  input  logic          fault_inject,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] c,
  output logic          out_valid,
  output logic [RW-1:0] y,
  output logic          bist_done,
  output logic          bist_pass,
  output logic [IW-1:0] bist_fail_idx
);

  typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;

  localparam int PW = 2*WIDTH;
  // c is one bit wider so the BIST addend 2*i never wraps
  localparam int CW = WIDTH+1;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          dcnt, dcnt_n;

  logic issue, accept, rerun, mism, fail_seen;

  logic [WIDTH-1:0] op_x1, op_x2, op_v, op_t;
  logic [CW-1:0]    op_c;
  logic [RW-1:0]    gi, gold;

  logic          s1_valid, s1_bist;
  logic [IW-1:0] s1_idx;
  logic [RW-1:0] s1_gold;
  logic [PW-1:0] s1_p1, s1_p2;
  logic [CW-1:0] s1_c;

  logic          s2_valid, s2_bist;
  logic [IW-1:0] s2_idx;
  logic [RW-1:0] s2_gold, s2_y;

  logic          o_valid;
  logic [RW-1:0] o_y;

  assign issue     = (state == RUN);
  assign accept    = in_valid & in_ready;
  assign rerun     = bist_start &
                     ((state == PASS) || (state == FAIL));
  assign mism      = s2_valid & s2_bist &
                     (s2_y != s2_gold);
  assign fail_seen = (bist_fail_idx != '0) | mism;

  assign in_ready  = (state == PASS);
  assign bist_done = (state == PASS) || (state == FAIL);
  assign bist_pass = (state == PASS);
  assign out_valid = o_valid;
  assign y         = o_y;

  // Operand source: generated vector in RUN, else the ports
  always_comb begin
    gi    = RW'(idx);
    gold  = gi*gi + RW'(5)*gi;
    op_x1 = x1;
    op_x2 = x2;
    op_v  = v;
    op_t  = t;
    op_c  = {1'b0, c};
    if (issue) begin
      op_x1 = WIDTH'(idx);
      op_x2 = WIDTH'(idx) + WIDTH'(1);
      op_v  = WIDTH'(idx);
      op_t  = WIDTH'(2);
      op_c  = CW'(idx) << 1;
    end
  end

  // Next-state logic for the self-test sequencer
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dcnt_n  = dcnt;
    unique case (state)
      RUN: begin
        if (idx == IW'(NUM_VECTORS)) begin
          state_n = DRAIN;
          dcnt_n  = 1'b0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      DRAIN: begin
        if (dcnt)
          state_n = fail_seen ? FAIL : PASS;
        else
          dcnt_n = 1'b1;
      end
      PASS, FAIL: begin
        if (bist_start) begin
          state_n = RUN;
          idx_n   = IW'(1);
        end
      end
      default: begin
        state_n = RUN;
        idx_n   = IW'(1);
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      idx   <= IW'(1);
      dcnt  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dcnt  <= dcnt_n;
    end
  end

  // Stage 1: products plus the BIST sideband
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_bist  <= 1'b0;
      s1_idx   <= '0;
      s1_gold  <= '0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_c     <= '0;
    end else begin
      s1_valid <= issue | accept;
      s1_bist  <= issue;
      if (issue | accept) begin
        s1_idx  <= issue ? idx : '0;
        s1_gold <= issue ? gold : '0;
        s1_p1   <= PW'(op_x1) * PW'(op_x2);
        s1_p2   <= PW'(op_v) * PW'(op_t);
        s1_c    <= op_c;
      end
    end
  end

  // Stage 2: sum, with the fault hook on bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_bist  <= 1'b0;
      s2_idx   <= '0;
      s2_gold  <= '0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_bist  <= s1_valid & s1_bist;
      if (s1_valid) begin
        s2_idx  <= s1_idx;
        s2_gold <= s1_gold;
        s2_y    <= (RW'(s1_p1) + RW'(s1_p2) +
                    RW'(s1_c)) ^ RW'(fault_inject);
      end
    end
  end

  // Result register: holds the last stage-2 value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_y     <= '0;
    end else begin
      o_valid <= s2_valid & ~s2_bist;
      if (s2_valid)
        o_y <= s2_y;
    end
  end

  // First failing vector index, cleared on re-run
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bist_fail_idx <= '0;
    else if (rerun)
      bist_fail_idx <= '0;
    else if (mism && (bist_fail_idx == '0))
      bist_fail_idx <= s2_idx;
  end

endmodule

// File: tb/tb_bist_mac_engine.sv
// tb_bist_mac_engine: randomized bench for bist_mac_engine
// against an arithmetic reference model.
module tb_bist_mac_engine;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int RW = 2*W+2;
  localparam int IW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          bist_start;
  logic          fault_inject;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x1, x2, v, t, c;
  logic          out_valid;
  logic [RW-1:0] y;
  logic          bist_done;
  logic          bist_pass;
  logic [IW-1:0] bist_fail_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bist_mac_engine #(.WIDTH(W), .NUM_VECTORS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .bist_start   (bist_start),
    .fault_inject (fault_inject),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x1           (x1),
    .x2           (x2),
    .v            (v),
    .t            (t),
    .c            (c),
    .out_valid    (out_valid),
    .y            (y),
    .bist_done    (bist_done),
    .bist_pass    (bist_pass),
    .bist_fail_idx(bist_fail_idx)
  );

  function automatic logic [RW-1:0] mac(
    input longint a, input longint b, input longint p,
    input longint q, input longint e);
    return RW'(a*b + p*q + e);
  endfunction

  task automatic idle_inputs;
    bist_start   = 1'b0;
    fault_inject = 1'b0;
    in_valid     = 1'b0;
    x1 = '0; x2 = '0; v = '0; t = '0; c = '0;
  endtask

  task automatic rand_ops;
    x1 = W'($urandom); x2 = W'($urandom);
    v  = W'($urandom); t  = W'($urandom);
    c  = W'($urandom);
  endtask

  // One BIST run; the next posedge is the first RUN edge.
  task automatic bist_seq(input logic [N:1] mask,
                          input bit noise,
                          input bit fl_v,
                          input logic [RW-1:0] fl_y);
    int exp_idx;
    logic [RW-1:0] g;
    logic exp_ov;
    exp_idx = 0;
    for (int i = N; i >= 1; i--)
      if (mask[i]) exp_idx = i;
    for (int e = 1; e <= N+2; e++) begin
      fault_inject = (e >= 2 && e <= N+1) ? mask[e-1] : (&mask);
      bist_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      exp_ov = (e == 2) && fl_v;
      total++;
      if (out_valid !== exp_ov) begin
        bad++;
        $display("FAIL bist_out_valid e=%0d got=%0b want=%0b",
                 e, out_valid, exp_ov);
      end
      if (exp_ov) begin
        total++;
        if (y !== fl_y) begin
          bad++;
          $display("FAIL inflight_y got=%0d want=%0d", y, fl_y);
        end
      end
      if (e >= 3) begin
        g = RW'((e-2)*(e-2) + 5*(e-2)) ^ RW'(mask[e-2]);
        total++;
        if (y !== g) begin
          bad++;
          $display("FAIL bist_y vec=%0d got=%0d want=%0d",
                   e-2, y, g);
        end
      end
      if (e < N+2) begin
        total++;
        if (bist_done !== 1'b0) begin
          bad++;
          $display("FAIL early_done e=%0d got=%0b want=0",
                   e, bist_done);
        end
      end
    end
    fault_inject = 1'b0;
    bist_start   = 1'b0;
    total++;
    if ({bist_done, bist_pass, in_ready, bist_fail_idx} !==
        {1'b1, exp_idx == 0, exp_idx == 0, IW'(exp_idx)}) begin
      bad++;
      $display("FAIL verdict got done=%0b pass=%0b rdy=%0b idx=%0d want 1/%0b/%0b/%0d",
               bist_done, bist_pass, in_ready, bist_fail_idx,
               exp_idx == 0, exp_idx == 0, exp_idx);
    end
  endtask

  task automatic kick;
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    total++;
    if ({bist_done, in_ready} !== 2'b00) begin
      bad++;
      $display("FAIL kick_done got done=%0b rdy=%0b want 0/0",
               bist_done, in_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, bist_done, bist_pass,
         bist_fail_idx, y} !== '0) begin
      bad++;
      $display("FAIL reset_vals rdy=%0b ov=%0b done=%0b pass=%0b idx=%0d y=%0d want all 0",
               in_ready, out_valid, bist_done, bist_pass,
               bist_fail_idx, y);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bist_pass;
    bist_seq('0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_normal_traffic;
    logic          ev[$];
    logic [RW-1:0] eq[$];
    logic          fv;
    logic [RW-1:0] fy;
    ev = '{1'b0, 1'b0, 1'b0};
    eq = '{RW'(0), RW'(0), RW'(0)};
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL normal_ready got=%0b want=1", in_ready);
    end
    for (int n = 0; n < 43; n++) begin
      fv = ev.pop_front();
      fy = eq.pop_front();
      total++;
      if (out_valid !== fv) begin
        bad++;
        $display("FAIL normal_valid n=%0d got=%0b want=%0b",
                 n, out_valid, fv);
      end
      if (fv) begin
        total++;
        if (y !== fy) begin
          bad++;
          $display("FAIL normal_y n=%0d got=%0d want=%0d",
                   n, y, fy);
        end
      end
      if (n == 0) begin
        in_valid = 1'b1;
        x1 = 8'd3; x2 = 8'd4; v = 8'd5; t = 8'd6; c = 8'd7;
      end else if (n <= 3) begin
        in_valid = 1'b1;
        x1 = '1; x2 = '1; v = '1; t = '1; c = '1;
      end else if (n < 40) begin
        in_valid = 1'($urandom_range(0, 1));
        rand_ops();
      end else begin
        in_valid = 1'b0;
      end
      ev.push_back(in_valid);
      eq.push_back(mac(x1, x2, v, t, c));
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_fault_held;
    kick();
    fault_inject = 1'b1;
    bist_seq('1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_fail_blocks;
    for (int n = 0; n < 8; n++) begin
      in_valid = (n < 5);
      rand_ops();
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, bist_done} !== 3'b001) begin
        bad++;
        $display("FAIL fail_blocks n=%0d rdy=%0b ov=%0b done=%0b want 0/0/1",
                 n, in_ready, out_valid, bist_done);
      end
    end
    idle_inputs();
  endtask

  task automatic test_fault_single;
    kick();
    bist_seq(4'b0100, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random_faults;
    logic [N:1] m;
    for (int k = 0; k < 8; k++) begin
      m = N'($urandom);
      kick();
      bist_seq(m, 1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_rerun_pass;
    kick();
    bist_seq('0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_start_inflight;
    logic [RW-1:0] e;
    rand_ops();
    in_valid   = 1'b1;
    e          = mac(x1, x2, v, t, c);
    kick();
    in_valid   = 1'b0;
    bist_seq('0, 1'b0, 1'b1, e);
  endtask

  task automatic test_reset_mid_traffic;
    rand_ops();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, bist_done, bist_pass,
         bist_fail_idx, y} !== '0) begin
      bad++;
      $display("FAIL reset_traffic rdy=%0b ov=%0b done=%0b pass=%0b idx=%0d y=%0d want all 0",
               in_ready, out_valid, bist_done, bist_pass,
               bist_fail_idx, y);
    end
    @(negedge clk);
    reset = 1'b0;
    bist_seq('0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid_run;
    kick();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, bist_done, bist_pass,
         bist_fail_idx, y} !== '0) begin
      bad++;
      $display("FAIL reset_run rdy=%0b ov=%0b done=%0b pass=%0b idx=%0d y=%0d want all 0",
               in_ready, out_valid, bist_done, bist_pass,
               bist_fail_idx, y);
    end
    @(negedge clk);
    reset = 1'b0;
    bist_seq('0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_bist_pass();
    test_normal_traffic();
    test_fault_held();
    test_fail_blocks();
    test_fault_single();
    test_random_faults();
    test_rerun_pass();
    test_start_inflight();
    test_normal_traffic();
    test_reset_mid_traffic();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
